// File: rtl/apb_slv_memory_strb_if.sv
// APB bus bundle for the strobed memory slave.
//   master modport : drives PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB, samples PREADY/PRDATA/PSLVERR
//   slave  modport : the mirror image
interface apb_slv_memory_strb_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 32
);
  logic [ADDR_SIZE-1:0]   PADDR;
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [DATA_SIZE-1:0]   PWDATA;
  logic [DATA_SIZE/8-1:0] PSTRB;
  logic                   PREADY;
  logic [DATA_SIZE-1:0]   PRDATA;
  logic                   PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_slv_memory_strb.sv
// APB slave backed by a DEPTH x DATA_SIZE register memory with byte strobes
// and a fixed number of wait states per access.
//   PCLK    : clock, rising edge
//   PRESET  : asynchronous active-high reset; clears FSM, outputs and memory
//   apb     : APB slave port (address/control/data in, PREADY/PRDATA/PSLVERR out)
// Storage is split into one 8-bit-wide column per byte lane so each strobe
// bit maps directly onto a lane's write enable.

// One byte lane of the memory: DEPTH bytes, async-cleared.
module apb_slv_memory_strb_lane #(
  parameter int DEPTH = 32,
  parameter int IW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Only consumed when the index is known in range.
  assign rdata = mem[idx];
endmodule

module apb_slv_memory_strb #(
  parameter int DATA_SIZE   = 32,
  parameter int ADDR_SIZE   = 8,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic PCLK,
  input logic PRESET,
  apb_slv_memory_strb_if.slave apb
);
  localparam int NUM_LANES = DATA_SIZE / 8;
  localparam int ALIGN     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 0;
  localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic                 write;
    logic [DATA_SIZE-1:0] wdata;
    logic [NUM_LANES-1:0] strb;
  } req_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  req_t req;
  logic load, ready;

  logic setup;
  assign setup = apb.PSEL & ~apb.PENABLE;

  // State, counter and captured request.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) req <= {apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          load      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!apb.PSEL) begin
          state_nxt = IDLE;                 // master abandoned the transfer
        end else if (!apb.PENABLE) begin
          load      = 1'b1;                 // new setup mid-transfer: restart on it
        end else if (cnt != 4'd0) begin
          cnt_nxt   = cnt - 4'd1;
        end else begin
          ready     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Completion cycle may already carry the next setup phase.
        if (setup) begin
          load      = 1'b1;
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) cnt_nxt = 4'(WAIT_CYCLES);
  end

  // Address decode from the captured request.
  logic [31:0]   idx32;
  logic [IW-1:0] mem_idx;
  logic          misaligned, out_of_range, err;

  assign idx32        = 32'(req.addr) >> ALIGN;
  assign mem_idx      = idx32[IW-1:0];
  assign misaligned   = |(req.addr & ADDR_SIZE'((1 << ALIGN) - 1));
  assign out_of_range = idx32 >= 32'(DEPTH);
  assign err          = misaligned | out_of_range;

  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_rdata;

  assign lane_we = {NUM_LANES{ready & req.write & ~err}} & req.strb;

  apb_slv_memory_strb_lane #(.DEPTH(DEPTH), .IW(IW)) u_lane [NUM_LANES-1:0] (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (lane_we),
    .idx   (mem_idx),
    .wdata (req.wdata),
    .rdata (lane_rdata)
  );

  // Outputs are pure decodes of state, so reset clears them without a clock.
  assign apb.PREADY  = ready;
  assign apb.PSLVERR = ready & err;
  assign apb.PRDATA  = (ready & ~req.write & ~err) ? DATA_SIZE'(lane_rdata) : '0;
endmodule

// File: doc/apb_slv_memory_strb.md
APB_SLV_MEMORY_STRB -- requirements
Module: apb_slv_memory_strb

Interface
REQ-001 Parameter DATA_SIZE, default 32, data bus width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_SIZE, default 8, byte-address width of PADDR.
REQ-003 Parameter DEPTH, default 32, number of DATA_SIZE-bit words implemented.
REQ-004 Parameter WAIT_CYCLES, default 2, range 0..15, wait states inserted in each access phase.
REQ-005 PCLK  input  1  clock; all state changes on rising edge.
REQ-006 PRESET  input  1  reset; asynchronous, active-high.
REQ-007 PADDR  input  ADDR_SIZE  byte address.
REQ-008 PSEL  input  1  slave select.
REQ-009 PENABLE  input  1  access-phase marker.
REQ-010 PWRITE  input  1  1 = write, 0 = read.
REQ-011 PWDATA  input  DATA_SIZE  write data.
REQ-012 PSTRB  input  DATA_SIZE/8  write byte-lane enables; bit i covers PWDATA[8i+7:8i].
REQ-013 PREADY  output  1  transfer-complete indication.
REQ-014 PRDATA  output  DATA_SIZE  read data.
REQ-015 PSLVERR  output  1  transfer error; meaningful only when PREADY=1.

Function
REQ-016 Word index SHALL be PADDR >> log2(DATA_SIZE/8); the low log2(DATA_SIZE/8) bits of PADDR are alignment bits.
REQ-017 FSM states SHALL be IDLE, WAIT and DONE.
REQ-018 IDLE: PSEL=1 with PENABLE=0 (setup phase) SHALL capture PADDR, PWRITE, PWDATA and PSTRB, load the wait counter with WAIT_CYCLES, and go to WAIT; otherwise stay in IDLE.
REQ-019 WAIT: while PSEL=1, PENABLE=1 and counter > 0, the counter SHALL decrement by 1 and PREADY SHALL stay 0.
REQ-020 WAIT: when counter = 0 with PSEL=1 and PENABLE=1, PREADY SHALL be 1 for exactly that cycle and the FSM SHALL go to DONE; with WAIT_CYCLES=0 this is the first access cycle.
REQ-021 DONE SHALL return to IDLE on the next edge; a new setup phase in that cycle SHALL be captured as in REQ-018 (back-to-back, no idle cycle required).
REQ-022 Error: word index >= DEPTH, or nonzero alignment bits, SHALL give PSLVERR=1 in the PREADY cycle; no write; PRDATA=0.
REQ-023 Write without error SHALL update, at the PREADY edge, only the byte lanes with PSTRB=1; PSTRB all zero SHALL leave memory unchanged and give PSLVERR=0.
REQ-024 Read without error SHALL drive the full addressed word on PRDATA in the PREADY cycle; PSTRB SHALL be ignored on reads.
REQ-025 PRDATA SHALL be 0 in every cycle other than a successful read's PREADY cycle; PSLVERR SHALL be 0 whenever PREADY=0.
REQ-026 PSEL=0 while in WAIT SHALL abort the transfer: return to IDLE, no write, PREADY stays 0.
REQ-027 PSEL=1 with PENABLE=0 while in WAIT (protocol violation) SHALL discard the pending transfer and capture the new setup as in REQ-018.
REQ-028 Captured address, control and data SHALL be used for the whole transfer, so input changes after setup have no effect.

Reset
REQ-029 PRESET=1 SHALL immediately force FSM=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0 and all DEPTH words to 0, regardless of PCLK.
REQ-030 Reset asserted mid-transfer SHALL cancel it with no memory write; after release the first setup phase SHALL be accepted normally.

Verification (DATA_SIZE=32, ADDR_SIZE=8, DEPTH=32, WAIT_CYCLES=2)
REQ-031 Write 0xDEADBEEF to 0x10 with PSTRB=0xF, then read 0x10 -> PREADY high on the 3rd access cycle of each transfer; read returns 0xDEADBEEF with PSLVERR=0.
REQ-032 Write 0x11223344 to 0x08 with PSTRB=0xF, then 0xAABBCCDD with PSTRB=0x5, then read 0x08 -> 0x11BB33DD.
REQ-033 Write to 0x80 (word 32) and read 0x02 (misaligned) -> PSLVERR=1 and PRDATA=0 in the PREADY cycle; a following read of 0x00 returns 0 and shows no memory change.
REQ-034 Deassert PSEL after one wait cycle of a write of 0x55 to 0x04 -> PREADY never asserts; a later read of 0x04 returns 0.
REQ-035 Pulse PRESET asynchronously (between PCLK edges) during the WAIT state of a read after writing 0xCAFEF00D to 0x0C -> outputs are 0 at once; a subsequent read of 0x0C returns 0.
REQ-036 Two back-to-back writes (setup directly after PREADY) to 0x00 and 0x04, then reads of both -> both values are returned intact with no idle cycle inserted between the writes.
